rv32_regfile: RTL

Integer register file for the RV32 core: the receiving end of the writeback stage's commit interface. Holds 32 × DATA_W architectural registers with x0 hardwired to zero. Serves two combinational read ports to decode/issue and one synchronous write port driven by writeback. Includes a per-register busy scoreboard (set at issue, cleared at commit) so issue can detect RAW hazards.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/rv32_scoreboard.sv | 46 ++++
 rtl/rv32_regfile.sv | 99 +++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 core constants and types.
//   XLEN      : architectural register width
//   RF_ADDR_W : register index width
//   NUM_REGS  : architectural register count
//   reg_idx_t : register index type
package rv32_pkg;
  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rv32_scoreboard.sv
// Busy scoreboard for the integer register file. One bit per architectural
// register, set when issue allocates a destination and cleared when
// writeback commits it. Flush clears everything. x0 is never busy.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   flush_i               clear every busy bit
//   commit_we_i/addr_i    commit from writeback (clears)
//   alloc_valid_i/addr_i  destination allocation from issue (sets)
//   busy_vec_o            registered busy vector
module rv32_scoreboard
  import rv32_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 commit_we_i,
  input  logic [ADDR_W-1:0]    commit_addr_i,
  input  logic                 alloc_valid_i,
  input  logic [ADDR_W-1:0]    alloc_addr_i,
  output logic [2**ADDR_W-1:0] busy_vec_o
);

  logic [2**ADDR_W-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (commit_we_i)   busy_d[commit_addr_i] = 1'b0;
      // Set after clear: a same-index alloc is a newer producer and wins.
      if (alloc_valid_i) busy_d[alloc_addr_i]  = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/rv32_regfile.sv
// RV32 integer register file: 2**RF_ADDR_W x DATA_W registers, x0 reads 0.
// Two combinational read ports, one synchronous commit port, and a busy
// scoreboard for RAW hazard detection at issue.
// Optional feature macro: RF_BYPASS_EN -- forwards same-cycle commit data
// to the read ports and suppresses the matching busy indication.
// Ports:
//   clk_i, rst_i                          clock, async active-high reset
//   rd_we_i, rd_waddr_i, rd_wdata_i       commit from writeback
//   rs1_addr_i/rs2_addr_i                 read indices
//   rs1_data_o/rs2_data_o                 read data (combinational)
//   alloc_valid_i, alloc_addr_i           destination allocation from issue
//   flush_i                               clear all busy bits
//   rs1_busy_o/rs2_busy_o                 outstanding-producer flags
//   busy_vec_o                            raw scoreboard
module rv32_regfile
  import rv32_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int RF_ADDR_W = rv32_pkg::RF_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_we_i,
  input  logic [RF_ADDR_W-1:0]    rd_waddr_i,
  input  logic [DATA_W-1:0]       rd_wdata_i,
  input  logic [RF_ADDR_W-1:0]    rs1_addr_i,
  input  logic [RF_ADDR_W-1:0]    rs2_addr_i,
  output logic [DATA_W-1:0]       rs1_data_o,
  output logic [DATA_W-1:0]       rs2_data_o,
  input  logic                    alloc_valid_i,
  input  logic [RF_ADDR_W-1:0]    alloc_addr_i,
  input  logic                    flush_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  output logic [2**RF_ADDR_W-1:0] busy_vec_o
);

  localparam int NREGS  = 2**RF_ADDR_W;
  localparam int NPORTS = 2;

  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_vec;

  // Storage; flush does not block the write.
  always_comb begin
    regs_d = regs_q;
    if (rd_we_i && rd_waddr_i != '0) regs_d[rd_waddr_i] = rd_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rv32_scoreboard #(.ADDR_W(RF_ADDR_W)) u_sb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .commit_we_i   (rd_we_i),
    .commit_addr_i (rd_waddr_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .busy_vec_o    (busy_vec)
  );

  // Read ports, indexed 0 = rs1, 1 = rs2.
  logic [NPORTS-1:0][RF_ADDR_W-1:0] rs_addr;
  logic [NPORTS-1:0][DATA_W-1:0]    rs_data;
  logic [NPORTS-1:0]                rs_busy;

  assign rs_addr = {rs2_addr_i, rs1_addr_i};

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rs_data[p] = (rs_addr[p] == '0) ? '0 : regs_q[rs_addr[p]];
      rs_busy[p] = busy_vec[rs_addr[p]];
`ifdef RF_BYPASS_EN
      // Gated by reset so outputs stay 0 while reset is held.
      if (!rst_i && rd_we_i && rd_waddr_i == rs_addr[p] && rs_addr[p] != '0) begin
        rs_data[p] = rd_wdata_i;
        rs_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign rs1_data_o = rs_data[0];
  assign rs2_data_o = rs_data[1];
  assign rs1_busy_o = rs_busy[0];
  assign rs2_busy_o = rs_busy[1];
  assign busy_vec_o = busy_vec;

endmodule
